// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared state encoding, digit constants and sizing helper for mult_seq_ctrl
package mult_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DIGIT_W = 2;
  localparam int PP_W = 4;
  function automatic int digits(input int width);
    return width / DIGIT_W;
  endfunction
endpackage

// File: rtl/mul2x2_digit.sv
// mul2x2_digit: combinational 2-bit x 2-bit unsigned multiply
module mul2x2_digit
  import mult_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  output logic [PP_W-1:0]    p
);
  assign p = {2'b00, x} * {2'b00, y};
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: digit-serial WIDTHxWIDTH multiplier controller; MULT_SEQ_ZERO_SKIP_EN bypasses RUN for zero operands
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int DIGITS = digits(WIDTH);
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0] i_q, i_d, j_q, j_d;
  logic [CW:0] dsum;
  logic [PP_W-1:0] pp;
  mul2x2_digit u_mul (
    .x(a_q[{i_q, 1'b0} +: DIGIT_W]),
    .y(b_q[{j_q, 1'b0} +: DIGIT_W]),
    .p(pp)
  );
  assign dsum = {1'b0, i_q} + {1'b0, j_q};
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    i_d = i_q;
    j_d = j_q;
    if (state_q == IDLE && in_valid) begin
      a_d = a;
      b_d = b;
      acc_d = '0;
      i_d = '0;
      j_d = '0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
      state_d = (a == '0 || b == '0) ? DONE : RUN;
`else
      state_d = RUN;
`endif
    end else if (state_q == RUN) begin
      // partial product weight is 4^(i+j), i.e. a left shift by 2*(i+j)
      acc_d = acc_q + ((2*WIDTH)'(pp) << {dsum, 1'b0});
      j_d = j_q == LAST ? '0 : j_q + 1'b1;
      i_d = j_q == LAST ? (i_q == LAST ? '0 : i_q + 1'b1) : i_q;
      state_d = (i_q == LAST && j_q == LAST) ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      i_q <= i_d;
      j_q <= j_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q == RUN;
  assign product = acc_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: scoreboard bench for mult_seq_ctrl with WIDTH=8 directed vectors
module tb_mult_seq_ctrl;
  typedef struct {
    logic [15:0] p;
    int          lat;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [7:0] a = 0, b = 0;
  logic in_ready, out_valid, busy;
  logic [15:0] product;
  int cyc = 0, errs = 0, checks = 0, acc_cyc = 0, ov_cyc = 0;
  logic ov_prev = 0;
  exp_t q[$];
`ifdef MULT_SEQ_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 17;
`endif
  mult_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid && !ov_prev) begin
        ov_cyc = cyc;
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", cyc - acc_cyc, q[0].lat);
      end
      if (out_valid && q.size() != 0) chk("product", product, q[0].p);
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
    end
    ov_prev = out_valid;
  end
  task automatic issue(input logic [7:0] x, input logic [7:0] y, input int lat, input bit push, input bit keep);
    int n = 0;
    a = x;
    b = y;
    in_valid = 1;
    if (push) q.push_back('{p: 16'(x * y), lat: lat});
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 32'(n < 100), 1);
    @(posedge clk); #1;
    if (!keep) in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    rst = 0;
    @(posedge clk); #1;
    issue(8'hFF, 8'hFF, 17, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      chk("busy_run", busy, 1);
      chk("no_early_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    chk("busy_done", busy, 0);
    chk("valid_c17", out_valid, 1);
    drain();
    issue(8'd13, 8'd11, 17, 1, 0);
    a = 8'hAA;
    b = 8'hAA;
    drain();
    out_ready = 0;
    issue(8'd7, 8'd9, 17, 1, 0);
    for (int n = 0; n < 100 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid", out_valid, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_product", product, 16'd63);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    issue(8'd5, 8'd5, 17, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_product", product, 0);
    chk("midrst_busy", busy, 0);
    issue(8'd200, 8'd3, 17, 1, 0);
    drain();
    issue(8'h00, 8'h5A, ZLAT, 1, 0);
    drain();
    issue(8'd3, 8'd5, 17, 1, 1);
    issue(8'd255, 8'd2, 17, 1, 0);
    chk("b2b_spacing", acc_cyc - ov_cyc, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
